// File: rtl/arith_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : arith_pkg
//  Description : Shared arithmetic-datapath definitions. Holds the divider
//                state encoding, the lookahead slice width and a helper that
//                returns how many slices cover a given operand width.
//  Revision    : 1.0  initial release
// ============================================================================
package arith_pkg;

    localparam int SLICE = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Number of SLICE-bit lookahead slices needed to cover 'width' bits.
    function automatic int slice_count(input int width);
        return (width + SLICE - 1) / SLICE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_divider_if.sv
`default_nettype none
// ============================================================================
//  Module      : seq_divider_if
//  Description : Start/done handshake bundle between a controller (master)
//                and the sequential divider (slave).
//  Ports       : start, dividend, divisor   controller -> divider
//                busy, done, quotient,
//                remainder, div_by_zero     divider -> controller
//  Revision    : 1.0  initial release
// ============================================================================
interface seq_divider_if #(
    parameter int W = 8
);
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface
`default_nettype wire

// File: rtl/clsub4.sv
`default_nettype none
// ============================================================================
//  Module      : clsub4
//  Description : 4-bit borrow-lookahead subtractor, {bout, diff} = a - b - bin.
//                Every internal borrow is a flat sum-of-products of the
//                generate/propagate terms; slices ripple only through bout.
//  Ports       : a, b   minuend / subtrahend (4 bits)
//                bin    borrow in
//                diff   difference (4 bits)
//                bout   borrow out
//  Revision    : 1.0  initial release
// ============================================================================
module clsub4 (
    output logic [3:0] diff,
    output logic       bout,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       bin
);
    logic [3:0] w_g;   // this bit borrows regardless of incoming borrow
    logic [3:0] w_p;   // this bit passes an incoming borrow through
    logic [3:0] w_bw;  // borrow into each bit

    assign w_g = ~a & b;
    assign w_p = ~(a ^ b);

    assign w_bw[0] = bin;
    assign w_bw[1] = w_g[0] | (w_p[0] & bin);
    assign w_bw[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & bin);
    assign w_bw[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                   | (w_p[2] & w_p[1] & w_p[0] & bin);
    assign bout    = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                   | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                   | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & bin);

    assign diff = a ^ b ^ w_bw;
endmodule
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
//  Module      : seq_divider
//  Description : Iterative unsigned restoring divider, one quotient bit per
//                clock. Trial subtractions go through a chain of clsub4
//                borrow-lookahead slices.
//  Ports       : clk    rising-edge clock
//                rst_n  asynchronous active-low reset
//                bus    seq_divider_if.slave: start/dividend/divisor in,
//                       busy/done/quotient/remainder/div_by_zero out
//  Revision    : 1.0  initial release
// ============================================================================
module seq_divider
    import arith_pkg::*;
#(
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    seq_divider_if.slave     bus
);
    localparam int NS = slice_count(W + 1);
    localparam int NB = NS * SLICE;
    localparam int CW = $clog2(W + 1);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_RUN  = RUN;
    localparam logic [1:0] ST_DONE = DONE;

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [W-1:0]  r_dreg;
    logic [W-1:0]  r_rem;
    logic [W-1:0]  r_q;
    logic [W-1:0]  r_quotient;
    logic [W-1:0]  r_remainder;
    logic          r_dbz;

    logic [W:0]    w_r;
    logic [NB-1:0] w_a;
    logic [NB-1:0] w_b;
    logic [NB-1:0] w_diff;
    logic [NS:0]   w_bc;
    logic          w_borrow;
    logic [W-1:0]  w_rem_next;
    logic [W-1:0]  w_q_next;
    logic          w_unused_diff;

    // Partial remainder with the next dividend bit shifted in.
    assign w_r = {r_rem, r_q[W-1]};

    // Both operands zero-extended to a whole number of slices; the upper
    // padding bits are zero, so the final slice borrow equals the borrow of
    // the (W+1)-bit subtraction.
    assign w_a = {{(NB-W-1){1'b0}}, w_r};
    assign w_b = {{(NB-W){1'b0}}, r_dreg};

    assign w_bc[0] = 1'b0;

    generate
        for (genvar i = 0; i < NS; i++) begin : g_slice
            clsub4 u_sub (
                .diff (w_diff[i*SLICE +: SLICE]),
                .bout (w_bc[i+1]),
                .a    (w_a[i*SLICE +: SLICE]),
                .b    (w_b[i*SLICE +: SLICE]),
                .bin  (w_bc[i])
            );
        end
    endgenerate

    assign w_borrow   = w_bc[NS];
    // On borrow the trial failed: restore by keeping the unsubtracted value.
    assign w_rem_next = w_borrow ? w_r[W-1:0] : w_diff[W-1:0];
    assign w_q_next   = {r_q[W-2:0], ~w_borrow};

    // When no borrow occurs the difference fits in W bits, so the upper
    // difference bits carry no information.
    assign w_unused_diff = ^w_diff[NB-1:W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_dreg      <= '0;
            r_rem       <= '0;
            r_q         <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        r_dreg <= bus.divisor;
                        r_rem  <= '0;
                        r_q    <= bus.dividend;
                        if (bus.divisor == '0) begin
                            // No iterations: report immediately.
                            r_state     <= ST_DONE;
                            r_cnt       <= '0;
                            r_quotient  <= '1;
                            r_remainder <= bus.dividend;
                            r_dbz       <= 1'b1;
                        end else begin
                            r_state <= ST_RUN;
                            r_cnt   <= CW'(W);
                            r_dbz   <= 1'b0;
                        end
                    end else if (r_state == ST_DONE) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    r_rem <= w_rem_next;
                    r_q   <= w_q_next;
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_state     <= ST_DONE;
                        r_quotient  <= w_q_next;
                        r_remainder <= w_rem_next;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy        = (r_state == ST_RUN);
    assign bus.done        = (r_state == ST_DONE);
    assign bus.quotient    = r_quotient;
    assign bus.remainder   = r_remainder;
    assign bus.div_by_zero = r_dbz;
endmodule
`default_nettype wire
